fifo_rd_arbiter: RTL and testbench

// - Read-clock-domain scheduler draining NUM_CH async-FIFO read ports into one valid/ready stream.
// - Sits after the per-channel empty checkers. Drives each channel's r_en and muxes its head word.
// - Weighted round-robin: a granted channel keeps the grant for up to MAX_BURST back-to-back pops.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_rd_arbiter_rr_pick.sv | 38 +++
 rtl/fifo_rd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and helpers for the FIFO read-side arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Modulo increment; written as a compare so non-power-of-2 channel counts wrap correctly.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority encoder. It returns the first
//                requesting index found when scanning upward from base.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   base,
    output logic [CH_W-1:0]   pick,
    output logic              pick_vld
);

    int unsigned w_idx;

    always_comb begin
        w_idx    = 32'(base);
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!pick_vld && req[CH_W'(w_idx)]) begin
                pick     = CH_W'(w_idx);
                pick_vld = 1'b1;
            end
            w_idx = rr_next(w_idx, NUM_CH);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
// ============================================================================
//  Module      : fifo_rd_arbiter
//  Description : Weighted round-robin drain of NUM_CH async-FIFO read ports
//                into a single valid/ready stream with a registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                          r_clk,
    input  logic                          r_rst,
    input  logic [NUM_CH-1:0]             ch_empty,
    input  logic [NUM_CH*DATA_SIZE-1:0]   ch_rdata,
    output logic [NUM_CH-1:0]             ch_ren,
    output logic                          m_valid,
    output logic [DATA_SIZE-1:0]          m_data,
    output logic [CH_W-1:0]               m_ch,
    input  logic                          m_ready,
    output logic [CH_W-1:0]               grant_ch,
    output logic                          busy
);

    localparam logic [0:0] c_ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] c_ST_BURST = 1'(BURST);

    localparam int                    c_BEAT_W    = $clog2(MAX_BURST + 1);
    localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT = c_BEAT_W'(MAX_BURST - 1);

    logic [0:0]           r_state;
    logic [CH_W-1:0]      r_rr_ptr;
    logic [CH_W-1:0]      r_grant;
    logic [c_BEAT_W-1:0]  r_beat_cnt;
    logic                 r_m_valid;
    logic [DATA_SIZE-1:0] r_m_data;
    logic [CH_W-1:0]      r_m_ch;

    logic [CH_W-1:0]      w_pick;
    logic                 w_pick_vld;
    logic                 w_slot_free;
    logic                 w_pop;
    logic [CH_W-1:0]      w_pop_ch;
    logic [DATA_SIZE-1:0] w_pop_data;
    logic [CH_W-1:0]      w_pick_next;
    logic [CH_W-1:0]      w_grant_next;
    logic [DATA_SIZE-1:0] w_ch_word [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_ch_word[gi] = ch_rdata[gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req      (~ch_empty),
        .base     (r_rr_ptr),
        .pick     (w_pick),
        .pick_vld (w_pick_vld)
    );

    assign w_slot_free  = !r_m_valid || m_ready;
    assign w_pick_next  = CH_W'(rr_next(32'(w_pick), NUM_CH));
    assign w_grant_next = CH_W'(rr_next(32'(r_grant), NUM_CH));

    // Pop decision is combinational so the head word lands in the output register on the pop edge.
    always_comb begin
        w_pop    = 1'b0;
        w_pop_ch = r_grant;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_vld && w_slot_free) begin
                    w_pop    = 1'b1;
                    w_pop_ch = w_pick;
                end
            end
            default: begin
                if (!ch_empty[r_grant] && w_slot_free) begin
                    w_pop = 1'b1;
                end
            end
        endcase
        if (!r_rst) begin
            w_pop = 1'b0;
        end
    end

    assign w_pop_data = w_ch_word[w_pop_ch];

    always_comb begin
        ch_ren = '0;
        if (w_pop) begin
            ch_ren[w_pop_ch] = 1'b1;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ch    <= '0;
        end else if (w_pop) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_pop_data;
            r_m_ch    <= w_pop_ch;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            r_state    <= c_ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= c_BEAT_W'(1);
                        if (MAX_BURST > 1) begin
                            r_state <= c_ST_BURST;
                        end else begin
                            r_rr_ptr <= w_pick_next;
                        end
                    end
                end
                default: begin
                    // An empty granted channel releases the grant; the bubble cycle is intentional.
                    if (ch_empty[r_grant]) begin
                        r_state  <= c_ST_IDLE;
                        r_rr_ptr <= w_grant_next;
                    end else if (w_slot_free) begin
                        r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state  <= c_ST_IDLE;
                            r_rr_ptr <= w_grant_next;
                        end
                    end
                end
            endcase
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_ch     = r_m_ch;
    assign grant_ch = r_grant;
    assign busy     = (r_state == c_ST_BURST);

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
// ============================================================================
//  Module      : tb_fifo_rd_arbiter
//  Description : Self-checking bench for fifo_rd_arbiter with FIFO models and
//                an ordered scoreboard of expected output words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DATA_SIZE = 8;
    localparam int MAX_BURST = 4;
    localparam int CH_W      = 2;

    logic                        r_clk = 1'b0;
    logic                        r_rst = 1'b0;
    logic [NUM_CH-1:0]           ch_empty;
    logic [NUM_CH*DATA_SIZE-1:0] ch_rdata;
    logic [NUM_CH-1:0]           ch_ren;
    logic                        m_valid;
    logic [DATA_SIZE-1:0]        m_data;
    logic [CH_W-1:0]             m_ch;
    logic                        m_ready;
    logic [CH_W-1:0]             grant_ch;
    logic                        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_SIZE-1:0]      fq    [NUM_CH][$];
    logic [CH_W+DATA_SIZE-1:0] exp_q [$];

    fifo_rd_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_SIZE (DATA_SIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .r_clk    (r_clk),
        .r_rst    (r_rst),
        .ch_empty (ch_empty),
        .ch_rdata (ch_rdata),
        .ch_ren   (ch_ren),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ch     (m_ch),
        .m_ready  (m_ready),
        .grant_ch (grant_ch),
        .busy     (busy)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_SIZE-1:0] word(input int ch, input int n, input int salt);
        return DATA_SIZE'(salt + ch * 16 + n);
    endfunction

    task automatic drive_if();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i] = (fq[i].size() == 0);
            ch_rdata[i*DATA_SIZE +: DATA_SIZE] = (fq[i].size() == 0) ? '0 : fq[i][0];
        end
    endtask

    task automatic load(input int ch, input int n, input int salt);
        for (int k = 0; k < n; k++) fq[ch].push_back(word(ch, k, salt));
        drive_if();
    endtask

    task automatic push_exp(input int ch, input int first, input int last, input int salt);
        for (int k = first; k <= last; k++) exp_q.push_back({CH_W'(ch), word(ch, k, salt)});
    endtask

    task automatic do_reset();
        @(posedge r_clk); #1 r_rst = 1'b0;
        repeat (2) @(posedge r_clk);
        #1 r_rst = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge r_clk);
            cyc++;
            done = (exp_q.size() == 0) && !m_valid;
            for (int i = 0; i < NUM_CH; i++) if (fq[i].size() != 0) done = 1'b0;
        end
        check_eq({tag, "_drain"}, 32'(done), 32'd1);
    endtask

    // FIFO model: pop on the edge where ch_ren was high, update flags just after it.
    initial begin
        logic [NUM_CH-1:0] ren_s;
        forever begin
            @(negedge r_clk);
            ren_s = ch_ren;
            @(posedge r_clk);
            #1;
            for (int i = 0; i < NUM_CH; i++)
                if (ren_s[i] && fq[i].size() != 0) void'(fq[i].pop_front());
            drive_if();
        end
    end

    // Output monitor and protocol invariants.
    initial begin
        forever begin
            @(negedge r_clk);
            if (!r_rst) begin
                check_eq("ren_in_rst", 32'(ch_ren), 32'd0);
            end else begin
                check_eq("ren_vs_empty", 32'(ch_ren & ch_empty), 32'd0);
                check_eq("ren_onehot", 32'($countones(ch_ren) > 1), 32'd0);
                check_eq("ren_no_slot", 32'(m_valid && !m_ready && (|ch_ren)), 32'd0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0)
                        check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
                    else
                        check_eq("sb_word", 32'({m_ch, m_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] mv_seq;
        logic [4:0] busy_seq;
        logic [3:0] ren_exp [7];
        logic [6:0] busy_exp;

        m_ready = 1'b1;
        r_rst   = 1'b0;
        drive_if();

        // Reset with every channel non-empty, then the weighted round-robin order.
        for (int ch = 0; ch < NUM_CH; ch++) load(ch, 10, 0);
        for (int r = 0; r < 3; r++)
            for (int ch = 0; ch < NUM_CH; ch++)
                push_exp(ch, r * 4, r * 4 + ((r < 2) ? 4 : 2) - 1, 0);
        repeat (3) begin
            @(negedge r_clk);
            check_eq("rst_ren", 32'(ch_ren), 32'd0);
            check_eq("rst_valid", 32'(m_valid), 32'd0);
            check_eq("rst_mch", 32'(m_ch), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_grant", 32'(grant_ch), 32'd0);
        end
        @(posedge r_clk); #1 r_rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge r_clk);
            check_eq("burst_ren", 32'(ch_ren), 32'(1 << (k / 4)));
            check_eq("burst_busy", 32'(busy), 32'((k % 4) != 0));
        end
        wait_drain("burst");

        // Single channel: three back-to-back words, then a bubble back to IDLE.
        do_reset();
        load(2, 3, 8'h80);
        push_exp(2, 0, 2, 8'h80);
        for (int k = 0; k < 5; k++) begin
            @(negedge r_clk);
            if (k == 0) check_eq("single_ren", 32'(ch_ren), 32'h4);
            mv_seq[k]   = m_valid;
            busy_seq[k] = busy;
        end
        check_eq("single_valid_seq", 32'(mv_seq), 32'b01110);
        check_eq("single_busy_seq", 32'(busy_seq), 32'b01110);
        wait_drain("single");

        // Backpressure mid-burst: one held word, no pops, burst length preserved.
        do_reset();
        load(0, 6, 8'h40);
        push_exp(0, 0, 5, 8'h40);
        @(negedge r_clk);
        check_eq("bp_ren0", 32'(ch_ren), 32'h1);
        @(negedge r_clk);
        check_eq("bp_ren1", 32'(ch_ren), 32'h1);
        @(posedge r_clk); #1 m_ready = 1'b0;
        repeat (5) begin
            @(negedge r_clk);
            check_eq("bp_hold_valid", 32'(m_valid), 32'd1);
            check_eq("bp_hold_data", 32'(m_data), 32'(word(0, 1, 8'h40)));
            check_eq("bp_hold_ren", 32'(ch_ren), 32'd0);
            check_eq("bp_hold_busy", 32'(busy), 32'd1);
        end
        @(posedge r_clk); #1 m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge r_clk);
            check_eq("bp_resume_ren", 32'(ch_ren), 32'h1);
            check_eq("bp_resume_busy", 32'(busy), 32'(k < 2));
        end
        wait_drain("backpressure");

        // Granted channel runs empty mid-burst and releases.
        do_reset();
        load(1, 2, 8'h20);
        load(3, 3, 8'h20);
        push_exp(1, 0, 1, 8'h20);
        push_exp(3, 0, 2, 8'h20);
        ren_exp  = '{4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        busy_exp = 7'b1110110;
        for (int k = 0; k < 7; k++) begin
            @(negedge r_clk);
            check_eq("empty_ren", 32'(ch_ren), 32'(ren_exp[k]));
            check_eq("empty_busy", 32'(busy), 32'(busy_exp[k]));
        end
        wait_drain("empty");

        // Reset after two pops of ch0: in-flight word dropped, ch0 granted again.
        do_reset();
        load(0, 6, 8'h60);
        load(1, 3, 8'h60);
        push_exp(0, 0, 0, 8'h60);
        push_exp(0, 2, 5, 8'h60);
        push_exp(1, 0, 2, 8'h60);
        @(negedge r_clk);
        check_eq("mrst_ren0", 32'(ch_ren), 32'h1);
        @(negedge r_clk);
        check_eq("mrst_ren1", 32'(ch_ren), 32'h1);
        @(posedge r_clk); #1 r_rst = 1'b0;
        @(negedge r_clk);
        check_eq("mrst_ren_forced", 32'(ch_ren), 32'd0);
        @(negedge r_clk);
        check_eq("mrst_valid", 32'(m_valid), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_mch", 32'(m_ch), 32'd0);
        check_eq("mrst_mdata", 32'(m_data), 32'd0);
        check_eq("mrst_grant", 32'(grant_ch), 32'd0);
        @(posedge r_clk); #1 r_rst = 1'b1;
        @(negedge r_clk);
        check_eq("mrst_regrant_ren", 32'(ch_ren), 32'h1);
        check_eq("mrst_regrant_busy", 32'(busy), 32'd0);
        wait_drain("midreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
